// File: rtl/pkt_arb_pkg.sv
// Shared types and helpers for the packet arbiter/mux.
// Feature macro PKT_ARB_LOCK_EN enables packet locking.
package pkt_arb_pkg;

  localparam int MAX_N = 32;
  localparam int IW    = $clog2(MAX_N);

  typedef enum logic {
    IDLE,
    LOCKED
  } state_t;

  typedef struct packed {
    logic [MAX_N-1:0] onehot;
    logic [IW-1:0]    idx;
  } pick_t;

  // First request at or above ptr, wrapping modulo n.
  function automatic pick_t rr_pick(
    input logic [MAX_N-1:0] req,
    input logic [IW-1:0]    ptr,
    input int               n
  );
    pick_t p;
    int    i;
    logic  found;
    p     = '0;
    found = 1'b0;
    for (int k = 0; k < MAX_N; k++) begin
      i = (int'(ptr) + k) % n;
      if (!found && k < n && req[i]) begin
        found       = 1'b1;
        p.onehot[i] = 1'b1;
        p.idx       = IW'(i);
      end
    end
    return p;
  endfunction

  function automatic logic [IW-1:0] onehot_to_idx(
    input logic [MAX_N-1:0] oh
  );
    logic [IW-1:0] idx;
    idx = '0;
    for (int k = 0; k < MAX_N; k++) begin
      if (oh[k]) idx = idx | IW'(k);
    end
    return idx;
  endfunction

endpackage

// File: rtl/pkt_arb_mux_skid.sv
// Two-entry register slice; ready depends only on stored occupancy.
// Sustains one beat per cycle and preserves order.
module skid_buf #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_data
);

  logic [W-1:0] e0;
  logic [W-1:0] e1;
  logic [1:0]   cnt;
  logic         push;
  logic         pop;

  assign in_ready  = (cnt != 2'd2);
  assign out_valid = (cnt != 2'd0);
  assign out_data  = e0;
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= 2'd0;
      e0  <= '0;
      e1  <= '0;
    end else begin
      unique case ({push, pop})
        2'b10: begin
          if (cnt == 2'd0) e0 <= in_data;
          else             e1 <= in_data;
          cnt <= cnt + 2'd1;
        end
        2'b01: begin
          e0  <= e1;
          cnt <= cnt - 2'd1;
        end
        2'b11: begin
          // push implies cnt < 2, so only one or zero entries are stored
          if (cnt == 2'd1) begin
            e0 <= in_data;
          end else begin
            e0 <= e1;
            e1 <= in_data;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/pkt_arb_mux.sv
// Round-robin N:1 packet mux with registered skid output.
// PKT_ARB_LOCK_EN holds the grant until the winner's last beat.
module pkt_arb_mux
  import pkt_arb_pkg::*;
#(
  parameter  int N  = 4,
  parameter  int DW = 32,
  localparam int SW = $clog2(N)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [N-1:0]  in_valid,
  input  logic [N*DW-1:0] in_data,
  input  logic [N-1:0]  in_last,
  output logic [N-1:0]  in_ready,
  output logic          out_valid,
  output logic [DW-1:0] out_data,
  output logic          out_last,
  output logic [SW-1:0] out_src,
  input  logic          out_ready
);

  localparam int PW = DW + 1 + SW;

  logic          can_acc;
  logic [N-1:0]  grant;
  logic [N-1:0]  xfer_vec;
  logic          xfer;
  pick_t         pk;
  logic [IW-1:0] acc_w;
  logic [SW-1:0] acc_idx;
  logic [SW-1:0] ptr;
  logic [SW-1:0] ptr_nxt;
  logic [DW-1:0] beat_data;
  logic          beat_last;
  logic [PW-1:0] skid_out;

`ifdef PKT_ARB_LOCK_EN
  state_t        state;
  state_t        state_nxt;
  logic [SW-1:0] lock_src;
  logic [SW-1:0] lock_nxt;
`endif

  function automatic logic [SW-1:0] wrap_inc(input logic [SW-1:0] i);
    return (i == SW'(N - 1)) ? '0 : i + 1'b1;
  endfunction

  assign pk        = rr_pick(MAX_N'(in_valid), IW'(ptr), N);
  assign in_ready  = grant;
  assign xfer_vec  = grant & in_valid;
  assign xfer      = |xfer_vec;
  assign acc_w     = onehot_to_idx(MAX_N'(xfer_vec));
  assign acc_idx   = acc_w[SW-1:0];
  assign beat_data = in_data[acc_idx*DW +: DW];
  assign beat_last = in_last[acc_idx];

  always_comb begin
    ptr_nxt = ptr;
    grant   = '0;
`ifdef PKT_ARB_LOCK_EN
    state_nxt = state;
    lock_nxt  = lock_src;
    unique case (state)
      IDLE:   if (can_acc) grant = pk.onehot[N-1:0];
      LOCKED: if (can_acc) grant = N'(1) << lock_src;
      default: ;
    endcase
    if (xfer) begin
      if (beat_last) begin
        state_nxt = IDLE;
        ptr_nxt   = wrap_inc(acc_idx);
      end else begin
        state_nxt = LOCKED;
        lock_nxt  = acc_idx;
      end
    end
`else
    if (can_acc) grant = pk.onehot[N-1:0];
    if (xfer) ptr_nxt = wrap_inc(acc_idx);
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr <= '0;
`ifdef PKT_ARB_LOCK_EN
      state    <= IDLE;
      lock_src <= '0;
`endif
    end else begin
      ptr <= ptr_nxt;
`ifdef PKT_ARB_LOCK_EN
      state    <= state_nxt;
      lock_src <= lock_nxt;
`endif
    end
  end

  skid_buf #(
    .W(PW)
  ) u_skid (
    .clk      (clk),
    .rst      (rst),
    .in_valid (xfer),
    .in_ready (can_acc),
    .in_data  ({beat_data, beat_last, acc_idx}),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data (skid_out)
  );

  assign {out_data, out_last, out_src} = skid_out;

endmodule

// File: tb/tb_pkt_arb_mux.sv
// Scoreboard bench for pkt_arb_mux; a reference arbiter predicts
// grants and the expected output stream for either build.
module tb_pkt_arb_mux;

  localparam int N  = 4;
  localparam int DW = 32;
  localparam int SW = 2;
  localparam int BW = DW + 1 + SW;

  logic          clk;
  logic          rst;
  logic [N-1:0]  in_valid;
  logic [N*DW-1:0] in_data;
  logic [N-1:0]  in_last;
  logic [N-1:0]  in_ready;
  logic          out_valid;
  logic [DW-1:0] out_data;
  logic          out_last;
  logic [SW-1:0] out_src;
  logic          out_ready;

  pkt_arb_mux #(
    .N (N),
    .DW(DW)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_data  (in_data),
    .in_last  (in_last),
    .in_ready (in_ready),
    .out_valid(out_valid),
    .out_data (out_data),
    .out_last (out_last),
    .out_src  (out_src),
    .out_ready(out_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  logic [DW:0]   srcq[N][$];
  logic [BW-1:0] sb[$];
  int            log_src[$];
  int            exp_q[$];
  logic [N-1:0]  en;
  logic          sink_rdy;
  int            ptr_m;
  bit            lock_m;
  int            lsrc_m;
  int            cnt_m;
  int            accepted;

  task automatic check_eq(input string tag, input logic [63:0] got,
                          input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    ptr_m  = 0;
    lock_m = 0;
    lsrc_m = 0;
    cnt_m  = 0;
    sb.delete();
  endtask

  task automatic do_reset();
    rst      = 1'b1;
    in_valid = '0;
    in_data  = '0;
    in_last  = '0;
    en       = '0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    model_reset();
    for (int i = 0; i < N; i++) srcq[i].delete();
    log_src.delete();
    #1;
    check_eq("rst_out_valid", out_valid, 0);
    check_eq("rst_in_ready", in_ready, 0);
    check_eq("rst_payload", {out_data, out_last, out_src}, 0);
  endtask

  task automatic load(input int s, input int n, input bit single,
                      input int tag);
    for (int b = 0; b < n; b++) begin
      logic [DW-1:0] d;
      d = {8'(s), 8'(tag), 16'(srcq[s].size() + b * 16)};
      srcq[s].push_back({(single || b == n - 1), d});
    end
  endtask

  task automatic run_cycle();
    logic [N-1:0] g;
    logic [N-1:0] x;
    logic [DW:0]  beat;
    int           w;
    int           pop;
    int           push;
    @(posedge clk);
    #1;
    out_ready = sink_rdy;
    for (int i = 0; i < N; i++) begin
      in_valid[i] = en[i] && (srcq[i].size() > 0);
      in_data[i*DW +: DW] = in_valid[i] ? srcq[i][0][DW-1:0] : '0;
      in_last[i] = in_valid[i] ? srcq[i][0][DW] : 1'b0;
    end
    #1;
    g = '0;
    if (cnt_m < 2) begin
      if (lock_m) begin
        g[lsrc_m] = 1'b1;
      end else begin
        for (int k = 0; k < N; k++) begin
          if (in_valid[(ptr_m + k) % N]) begin
            g[(ptr_m + k) % N] = 1'b1;
            break;
          end
        end
      end
    end
    check_eq("in_ready", in_ready, g);
    check_eq("out_valid", out_valid, cnt_m > 0);
    pop = 0;
    if (cnt_m > 0 && sb.size() > 0) begin
      check_eq("out_beat", {out_data, out_last, out_src}, sb[0]);
      if (sink_rdy) begin
        pop = 1;
        log_src.push_back(int'(out_src));
        void'(sb.pop_front());
      end
    end
    push = 0;
    x = g & in_valid;
    if (x != 0) begin
      w = 0;
      for (int i = 0; i < N; i++) if (x[i]) w = i;
      beat = srcq[w].pop_front();
      sb.push_back({beat[DW-1:0], beat[DW], SW'(w)});
      push = 1;
      accepted++;
`ifdef PKT_ARB_LOCK_EN
      if (beat[DW]) begin
        lock_m = 0;
        ptr_m  = (w + 1) % N;
      end else begin
        lock_m = 1;
        lsrc_m = w;
      end
`else
      ptr_m = (w + 1) % N;
`endif
    end
    cnt_m = cnt_m + push - pop;
  endtask

  task automatic drain();
    int n;
    bit busy;
    n = 0;
    busy = 1;
    while (busy && n < 200) begin
      run_cycle();
      n++;
      busy = (sb.size() > 0) || (cnt_m > 0);
      for (int i = 0; i < N; i++) if (srcq[i].size() > 0) busy = 1;
    end
    if (busy) check_eq("drain_timeout", 0, 1);
  endtask

  task automatic check_seq(input string tag, input int n);
    check_eq({tag, "_len"}, log_src.size() >= n, 1);
    for (int i = 0; i < n && i < log_src.size(); i++)
      check_eq(tag, log_src[i], exp_q[i]);
  endtask

  initial begin
    rst       = 1'b1;
    out_ready = 1'b0;
    sink_rdy  = 1'b1;
    accepted  = 0;
    do_reset();

    // all sources, single-beat packets
    for (int s = 0; s < N; s++) load(s, 2, 1, 1);
    en = '1;
    drain();
    exp_q = '{0, 1, 2, 3, 0, 1, 2, 3};
    check_seq("rr_single", 8);

    // 4-beat packet on src1 against a busy src2
    do_reset();
    load(1, 4, 0, 2);
    load(2, 3, 1, 2);
    en = '1;
    drain();
`ifdef PKT_ARB_LOCK_EN
    exp_q = '{1, 1, 1, 1, 2, 2, 2};
`else
    exp_q = '{1, 2, 1, 2, 1, 2, 1};
`endif
    check_seq("pkt_lock", 7);

    // valid gap on locked src0 while src3 waits
    do_reset();
    load(0, 3, 0, 3);
    load(3, 2, 1, 3);
    en = '1;
    run_cycle();
    en = 4'b1110;
    repeat (3) run_cycle();
    en = '1;
    drain();
`ifdef PKT_ARB_LOCK_EN
    exp_q = '{0, 0, 0, 3, 3};
`else
    exp_q = '{0, 3, 3, 0, 0};
`endif
    check_seq("gap_hold", 5);

    // sink stall fills the skid
    do_reset();
    load(1, 6, 0, 4);
    en = '1;
    sink_rdy = 1'b0;
    accepted = 0;
    repeat (5) run_cycle();
    check_eq("stall_accepts", accepted, 2);
    sink_rdy = 1'b1;
    drain();
    exp_q = '{1, 1, 1, 1, 1, 1};
    check_seq("stall_order", 6);

    // reset mid-packet, then priority back at src0
    do_reset();
    load(2, 3, 0, 5);
    en = '1;
    run_cycle();
    run_cycle();
    do_reset();
    load(0, 1, 1, 6);
    load(2, 1, 1, 6);
    en = '1;
    drain();
    exp_q = '{0, 2};
    check_seq("rst_mid", 2);

    // two 3-beat packets
    do_reset();
    load(0, 3, 0, 7);
    load(1, 3, 0, 7);
    en = '1;
    drain();
`ifdef PKT_ARB_LOCK_EN
    exp_q = '{0, 0, 0, 1, 1, 1};
`else
    exp_q = '{0, 1, 0, 1, 0, 1};
`endif
    check_seq("alt_pkts", 6);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/pkt_arb_mux.md
Name: pkt_arb_mux

Overview:
- Downstream consumer of round-robin grant selection. Takes N valid/ready packet sources and merges them onto one output stream.
- Arbitrates round-robin at packet boundaries and holds the grant until the winner's last beat transfers.
- Output is registered through a full-throughput skid stage. Sits between per-requester queues and a shared sink (bus/link).

Parameters:
- N, 4, number of input sources (≥2)
- DW, 32, data width per beat
- SW, $clog2(N), source-index width (derived, not overridden)

Ports:
- clk  input  1  clock, all logic on rising edge
- rst  input  1  synchronous, active-high reset
- in_valid  input  N  per-source beat valid
- in_data  input  N*DW  per-source data; source i at [i*DW +: DW]
- in_last  input  N  per-source last-beat-of-packet flag
- in_ready  output  N  per-source accept; at most one bit set
- out_valid  output  1  output beat valid
- out_data  output  DW  output beat data
- out_last  output  1  output last-beat flag
- out_src  output  SW  index of source that produced this beat
- out_ready  input  1  sink accept

Behaviour:
- Transfer occurs when valid && ready on a port in the same cycle. Sources must hold valid, data and last stable until accepted. in_ready never depends combinationally on out_ready (skid isolates it).
- Reset: state=IDLE, ptr=0 (source 0 highest priority), skid empty, out_valid=0, in_ready=0. out_data/out_last/out_src are don't-care while out_valid=0 but are reset to 0.
- FSM states:
  - IDLE:
    - If skid can accept, pick winner combinationally: first set in_valid bit searching from index ptr upward, wrapping modulo N. Assert in_ready[winner] in that same cycle.
    - On transfer with in_last=0, latch lock_src=winner and go to LOCKED.
    - On transfer with in_last=1 (single-beat packet), stay in IDLE and set ptr=(winner+1) mod N.
    - No valid inputs: stay in IDLE, ptr unchanged.
  - LOCKED:
    - in_ready[lock_src]=skid_can_accept; all other in_ready=0.
    - Transfer with in_last=1: go to IDLE, ptr=(lock_src+1) mod N.
    - Gaps in in_valid[lock_src] mid-packet hold the lock indefinitely.
- No bubble between packets: the cycle after a last beat is IDLE and can transfer a new first beat.
- Skid stage: 2 entries {data,last,src}.
  - skid_can_accept=1 when at least one entry is free.
  - Sustains 1 beat/cycle with out_ready=1.
  - Latency from input transfer to out_valid is 1 cycle.
  - Order preserved.
  - out_valid stays high with stable payload until out_ready.
- Boundaries:
  - Skid full: all in_ready=0; FSM and ptr frozen.
  - ptr wraps N-1→0.
  - Simultaneous output pop and input push while full is not possible (can_accept is computed from registered occupancy only).
- Reset asserted mid-packet: partial packet abandoned; skid contents discarded; the next beat from any source is treated as a packet start.

Optional Feature:
- Macro: PKT_ARB_LOCK_EN.
- Defined: packet locking exactly as above.
- Undefined: every beat arbitrated independently from IDLE. ptr advances to (winner+1) mod N on every transfer. in_last is passed through to out_last but does not affect arbitration. LOCKED state and lock_src are not built.

Decomposition:
- Package pkt_arb_pkg: state enum typedef (IDLE, LOCKED); function rr_pick(req, ptr) returning one-hot plus index; function onehot_to_idx.
- Sub-module skid_buf (params DW+1+SW width): 2-entry valid/ready register slice with in/out handshake. Instantiated once.

Test Plan:
- After reset, all in_valid=0xF, 1-beat packets, out_ready=1 → out_src sequence 0,1,2,3,0, one beat/cycle, first out_valid 1 cycle after the first transfer.
- Source 1 sends 4-beat packet (last on beat 4) while source 2 is continuously valid → all 4 beats with out_src=1 contiguous before any src 2 beat; then src 2 wins with ptr=2.
- Source 0 locked, in_valid[0] drops for 3 cycles mid-packet while source 3 is valid → in_ready[3] stays 0; lock held; source 0 completes.
- out_ready=0 for 5 cycles with continuous input → exactly 2 beats accepted, then all in_ready=0; out_data stable; on release, order and data intact.
- rst pulsed for 1 cycle during beat 2 of a 3-beat packet from src 2 → out_valid=0 next cycle, ptr=0; with src 0 and src 2 both valid, src 0 wins.
- Compile without PKT_ARB_LOCK_EN, src 0 and src 1 each sending 3-beat packets → out_src alternates 0,1,0,1,0,1.
